// File: rtl/writeback_pipe.sv
// Writeback stage: picks the result source, extracts and extends load data, waits a bounded
// time for memory, then commits one register write plus an optional jump request.
module writeback_pipe #(
   parameter int XLEN        = 32,
   parameter int MEM_TIMEOUT = 16
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            phase_writeback,
   input  logic [1:0]      use_rd,
   input  logic            jump_en,
   input  logic            jump_state_mw,
   input  logic [2:0]      ld_funct3,
   input  logic [4:0]      rdsel_mw,
   input  logic [XLEN-1:0] next_pc_mw,
   input  logic [XLEN-1:0] alu_out_mw,
   input  logic [XLEN-1:0] mem_out_mw,
   input  logic            mem_ready,
   output logic            rd_we,
   output logic [4:0]      rdsel_wr,
   output logic [XLEN-1:0] rddata_wr,
   output logic            jump_state_wf,
   output logic [XLEN-1:0] regdata_for_pc,
   output logic            stall_writeback,
   output logic            wb_err,
   output logic            fwd_valid,
   output logic [4:0]      fwd_rdsel,
   output logic [XLEN-1:0] fwd_data,
   output logic [1:0]      dbg_state_o
);
   localparam int OFFW = (XLEN == 64) ? 3 : 2;

   typedef enum logic [1:0] {IDLE = 2'd0, WAIT_MEM = 2'd1, COMMIT = 2'd2} state_t;

   state_t          state_q, state_d;
   logic [7:0]      cnt_q, cnt_d;
   logic [4:0]      rdsel_q, rdsel_wr_q, fwd_rdsel_q, cur_rdsel;
   logic [2:0]      f3_q;
   logic [OFFW-1:0] off_q;
   logic [XLEN-1:0] alu_q, rddata_wr_q, pc_q, fwd_data_q, cur_alu, result;
   logic            jump_q, wb_err_q, fwd_valid_q;
   logic            accept, need_wait, mem_timeout, to_commit;

   function automatic logic [XLEN-1:0] load_ext(input logic [2:0]      f3,
                                                input logic [OFFW-1:0] off,
                                                input logic [XLEN-1:0] d);
      logic [OFFW-1:0] off_h, off_w;
      logic [7:0]      b;
      logic [15:0]     h;
      logic [31:0]     w;
      off_h      = off;
      off_h[0]   = 1'b0;
      off_w      = off;
      off_w[1:0] = 2'b00;
      b = d[{off, 3'b000} +: 8];
      h = d[{off_h, 3'b000} +: 16];
      w = d[{off_w, 3'b000} +: 32];
      case (f3)
         3'b000:  load_ext = XLEN'($signed(b));
         3'b001:  load_ext = XLEN'($signed(h));
         3'b010:  load_ext = XLEN'($signed(w));
         3'b011:  load_ext = (XLEN == 64) ? d : '0;
         3'b100:  load_ext = XLEN'(b);
         3'b101:  load_ext = XLEN'(h);
         3'b110:  load_ext = (XLEN == 64) ? XLEN'(w) : '0;
         default: load_ext = '0;
      endcase
   endfunction

   // phase_writeback is a one-cycle request, taken only in IDLE; stall_writeback tells the
   // sequencer to hold while a load waits for mem_ready. No request is queued elsewhere.
   assign accept      = phase_writeback && (state_q == IDLE);
   assign need_wait   = accept && (use_rd == 2'b10) && !mem_ready;
   assign cnt_d       = cnt_q + 8'd1;
   assign mem_timeout = (state_q == WAIT_MEM) && !mem_ready && (cnt_d == 8'(MEM_TIMEOUT - 1));
   assign to_commit   = (state_d == COMMIT);
   assign cur_rdsel   = (state_q == IDLE) ? rdsel_mw : rdsel_q;
   assign cur_alu     = (state_q == IDLE) ? alu_out_mw : alu_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:     if (accept) state_d = need_wait ? WAIT_MEM : COMMIT;
         WAIT_MEM: begin
            if (mem_ready)        state_d = COMMIT;
            else if (mem_timeout) state_d = IDLE;
         end
         COMMIT:   state_d = IDLE;
         default:  state_d = IDLE;
      endcase
   end

   always_comb begin
      rd_we           = 1'b0;
      jump_state_wf   = 1'b0;
      stall_writeback = 1'b0;
      unique case (state_q)
         IDLE:     stall_writeback = need_wait;
         WAIT_MEM: stall_writeback = 1'b1;
         COMMIT: begin
            rd_we         = (rdsel_wr_q != 5'd0);
            jump_state_wf = jump_q;
         end
         default: ;
      endcase
   end

   // A pending load reads its size/offset from the captured operands, not the live inputs.
   always_comb begin
      result = '0;
      if (state_q == WAIT_MEM) begin
         result = load_ext(f3_q, off_q, mem_out_mw);
      end else begin
         case (use_rd)
            2'b00:   result = alu_out_mw;
            2'b01:   result = next_pc_mw;
            2'b10:   result = load_ext(ld_funct3, alu_out_mw[OFFW-1:0], mem_out_mw);
            default: result = XLEN'(jump_state_mw);
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q       <= '0;
         rdsel_q     <= '0;
         f3_q        <= '0;
         off_q       <= '0;
         alu_q       <= '0;
         jump_q      <= 1'b0;
         rdsel_wr_q  <= '0;
         rddata_wr_q <= '0;
         pc_q        <= '0;
         wb_err_q    <= 1'b0;
         fwd_valid_q <= 1'b0;
         fwd_rdsel_q <= '0;
         fwd_data_q  <= '0;
      end else begin
         wb_err_q <= mem_timeout;
         if (state_q == WAIT_MEM) cnt_q <= cnt_d;
         else                     cnt_q <= '0;
         if (accept) begin
            rdsel_q <= rdsel_mw;
            f3_q    <= ld_funct3;
            off_q   <= alu_out_mw[OFFW-1:0];
            alu_q   <= alu_out_mw;
            jump_q  <= jump_en && jump_state_mw;
         end
         if (to_commit) begin
            rdsel_wr_q  <= cur_rdsel;
            rddata_wr_q <= result;
            pc_q        <= cur_alu;
         end
         if (rd_we) begin
            fwd_valid_q <= 1'b1;
            fwd_rdsel_q <= rdsel_wr_q;
            fwd_data_q  <= rddata_wr_q;
         end
      end
   end

   assign rdsel_wr       = rdsel_wr_q;
   assign rddata_wr      = rddata_wr_q;
   assign regdata_for_pc = pc_q;
   assign wb_err         = wb_err_q;
   assign fwd_valid      = fwd_valid_q;
   assign fwd_rdsel      = fwd_rdsel_q;
   assign fwd_data       = fwd_data_q;
   assign dbg_state_o    = state_q;
endmodule

// File: tb/tb_writeback_pipe.sv
// Bench for writeback_pipe: directed corner cases plus random transactions, checked through an
// expected-event queue drained by a monitor and a byte-level reference model of loads.
module tb_writeback_pipe;
   localparam int XLEN = 32;
   localparam int MT   = 16;
   localparam int EW   = 1 + 1 + 5 + XLEN + 1 + XLEN;  // {err, we, rdsel, data, jmp, pc}

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            phase_writeback = 1'b0;
   logic [1:0]      use_rd = '0;
   logic            jump_en = 1'b0;
   logic            jump_state_mw = 1'b0;
   logic [2:0]      ld_funct3 = '0;
   logic [4:0]      rdsel_mw = '0;
   logic [XLEN-1:0] next_pc_mw = '0;
   logic [XLEN-1:0] alu_out_mw = '0;
   logic [XLEN-1:0] mem_out_mw = '0;
   logic            mem_ready = 1'b0;
   logic            rd_we, jump_state_wf, stall_writeback, wb_err, fwd_valid;
   logic [4:0]      rdsel_wr, fwd_rdsel;
   logic [XLEN-1:0] rddata_wr, regdata_for_pc, fwd_data;
   logic [1:0]      dbg_state;

   int checks = 0;
   int errors = 0;
   logic [EW-1:0] exp_q[$];

   logic            m_fwd_v;
   logic [4:0]      m_fwd_r, m_last_rd;
   logic [XLEN-1:0] m_fwd_d, m_last_data, m_last_pc;

   writeback_pipe #(.XLEN(XLEN), .MEM_TIMEOUT(MT)) dut (
      .clk(clk), .rst_n(rst_n), .phase_writeback(phase_writeback), .use_rd(use_rd),
      .jump_en(jump_en), .jump_state_mw(jump_state_mw), .ld_funct3(ld_funct3),
      .rdsel_mw(rdsel_mw), .next_pc_mw(next_pc_mw), .alu_out_mw(alu_out_mw),
      .mem_out_mw(mem_out_mw), .mem_ready(mem_ready), .rd_we(rd_we), .rdsel_wr(rdsel_wr),
      .rddata_wr(rddata_wr), .jump_state_wf(jump_state_wf), .regdata_for_pc(regdata_for_pc),
      .stall_writeback(stall_writeback), .wb_err(wb_err), .fwd_valid(fwd_valid),
      .fwd_rdsel(fwd_rdsel), .fwd_data(fwd_data), .dbg_state_o(dbg_state)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference load: gather the addressed bytes, then sign-extend arithmetically.
   function automatic logic [XLEN-1:0] load_ref(input logic [2:0] f3, input logic [XLEN-1:0] addr,
                                                input logic [XLEN-1:0] mem);
      int size, off, base;
      bit sgn;
      longint unsigned v;
      logic [7:0] bytes[XLEN/8];
      for (int i = 0; i < XLEN/8; i++) bytes[i] = mem[8*i +: 8];
      case (f3)
         3'd0: begin size = 1; sgn = 1; end
         3'd1: begin size = 2; sgn = 1; end
         3'd2: begin size = 4; sgn = 1; end
         3'd4: begin size = 1; sgn = 0; end
         3'd5: begin size = 2; sgn = 0; end
         default: return '0;
      endcase
      off  = int'(addr % (XLEN/8));
      base = off - (off % size);
      v = 0;
      for (int k = 0; k < size; k++) v = v | (longint'(bytes[base+k]) << (8*k));
      if (sgn && bytes[base+size-1][7]) v = v - (64'd1 << (8*size));
      return v[XLEN-1:0];
   endfunction

   task automatic model_reset();
      m_fwd_v = 0; m_fwd_r = 0; m_fwd_d = 0;
      m_last_rd = 0; m_last_data = 0; m_last_pc = 0;
   endtask

   task automatic check_all_zero(input string name);
      check(name, {rd_we, rdsel_wr, rddata_wr, jump_state_wf, regdata_for_pc, stall_writeback,
                   wb_err, fwd_valid, fwd_rdsel, fwd_data, dbg_state}, '0);
   endtask

   // Called at posedge+1 with the DUT idle. delay = cycles mem_ready stays low (loads only).
   task automatic run_txn(input logic [1:0] ur, input logic jen, input logic jst,
                          input logic [2:0] f3, input logic [4:0] rd, input logic [XLEN-1:0] pc,
                          input logic [XLEN-1:0] alu, input logic [XLEN-1:0] mem, input int delay);
      logic [XLEN-1:0] res;
      logic jmp, we;
      bit timeout;
      int last, stalls, dly;
      check("fwd_hold", {fwd_valid, fwd_rdsel, fwd_data}, {m_fwd_v, m_fwd_r, m_fwd_d});
      check("wr_hold", {rdsel_wr, rddata_wr, regdata_for_pc}, {m_last_rd, m_last_data, m_last_pc});
      dly = (ur == 2'b10) ? delay : 0;
      timeout = (dly >= MT);
      case (ur)
         2'b00:   res = alu;
         2'b01:   res = pc;
         2'b10:   res = load_ref(f3, alu, mem);
         default: res = XLEN'(jst);
      endcase
      jmp = jen & jst;
      we  = (rd != 0);
      if (timeout) exp_q.push_back({1'b1, 1'b0, 5'd0, {XLEN{1'b0}}, 1'b0, {XLEN{1'b0}}});
      else if (we || jmp) exp_q.push_back({1'b0, we, rd, res, jmp, alu});
      phase_writeback = 1; use_rd = ur; jump_en = jen; jump_state_mw = jst; ld_funct3 = f3;
      rdsel_mw = rd; next_pc_mw = pc; alu_out_mw = alu;
      mem_ready  = (ur == 2'b10) ? (dly == 0) : 1'($urandom_range(0, 1));
      mem_out_mw = (ur != 2'b10 || dly == 0) ? mem : $urandom;
      last   = timeout ? MT - 1 : dly;
      stalls = 0;
      for (int i = 0; i <= last; i++) begin
         if (i > 0) begin
            phase_writeback = 1'($urandom_range(0, 1));
            use_rd = 2'($urandom_range(0, 3)); ld_funct3 = 3'($urandom_range(0, 7));
            rdsel_mw = 5'($urandom_range(0, 31)); alu_out_mw = $urandom; next_pc_mw = $urandom;
            jump_en = 1'($urandom_range(0, 1)); jump_state_mw = 1'($urandom_range(0, 1));
            mem_ready  = !timeout && (i == dly);
            mem_out_mw = mem_ready ? mem : $urandom;
         end
         #1;
         if (stall_writeback) stalls++;
         @(posedge clk); #1;
      end
      phase_writeback = 0; mem_ready = 0;
      if (timeout) begin
         check("wb_err_pulse", wb_err, 1'b1);
         check("no_write_on_timeout", rd_we, 1'b0);
         check("timeout_stall_cycles", stalls, MT);
         @(posedge clk); #1;
         check("wb_err_one_cycle", wb_err, 1'b0);
      end else begin
         check("commit_rd_we", rd_we, we);
         check("stall_cycles", stalls, (dly > 0) ? dly + 1 : 0);
         m_last_rd = rd; m_last_data = res; m_last_pc = alu;
         if (we) begin m_fwd_v = 1; m_fwd_r = rd; m_fwd_d = res; end
         @(posedge clk); #1;
      end
   endtask

   task automatic reset_mid_wait();
      int seen;
      phase_writeback = 1; use_rd = 2'b10; ld_funct3 = 3'b010; rdsel_mw = 5'd7;
      alu_out_mw = 32'h100; mem_ready = 0;
      @(posedge clk); #1;
      phase_writeback = 0;
      @(posedge clk); #1;
      check("stall_in_wait", stall_writeback, 1'b1);
      rst_n = 0; #1;
      check_all_zero("reset_mid_wait_outputs");
      mem_ready = 1; mem_out_mw = 32'hDEAD_BEEF;
      @(posedge clk); #1;
      rst_n = 1; mem_ready = 0;
      model_reset();
      seen = 0;
      for (int i = 0; i < MT + 4; i++) begin
         @(negedge clk);
         if (rd_we || wb_err) seen++;
      end
      @(posedge clk); #1;
      check("no_event_after_reset", seen, 0);
   endtask

   // Monitor: every visible commit or error event must match the head of the queue.
   always @(negedge clk) begin
      logic [EW-1:0] e;
      if (rst_n && (rd_we || jump_state_wf || wb_err)) begin
         if (exp_q.size() == 0) begin
            check("unexpected_event", {wb_err, rd_we, jump_state_wf}, 3'b000);
         end else begin
            e = exp_q.pop_front();
            if (e[EW-1]) check("err_event", {wb_err, rd_we, jump_state_wf}, 3'b100);
            else check("commit_event", {wb_err, rd_we, rdsel_wr, rddata_wr, jump_state_wf,
                                        regdata_for_pc}, {1'b0, e[EW-2:0]});
         end
      end
   end

   initial begin
      int r, dly;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check_all_zero("reset_outputs");
      rst_n = 1;
      @(posedge clk); #1;

      run_txn(2'b00, 0, 0, 3'b000, 5'd5, 32'h40, 32'h0000_1234, 32'h0, 0);
      run_txn(2'b10, 0, 0, 3'b000, 5'd9, 32'h44, 32'h0000_2003, 32'h80FF_0000, 0);
      run_txn(2'b10, 0, 0, 3'b100, 5'd10, 32'h48, 32'h0000_2003, 32'h80FF_0000, 0);
      run_txn(2'b10, 0, 0, 3'b010, 5'd11, 32'h4C, 32'h0000_3000, 32'hCAFE_F00D, 3);
      run_txn(2'b10, 0, 0, 3'b010, 5'd12, 32'h50, 32'h0000_3004, 32'h1111_2222, MT + 5);
      run_txn(2'b11, 1, 1, 3'b000, 5'd0, 32'h54, 32'h0000_0800, 32'h0, 0);
      run_txn(2'b10, 1, 1, 3'b001, 5'd13, 32'h58, 32'h0000_0003, 32'h8765_4321, MT - 1);
      run_txn(2'b10, 0, 0, 3'b101, 5'd14, 32'h5C, 32'h0000_0001, 32'h8765_F321, 1);
      run_txn(2'b10, 0, 0, 3'b011, 5'd15, 32'h60, 32'h0000_0000, 32'hFFFF_FFFF, 0);
      run_txn(2'b10, 0, 0, 3'b111, 5'd16, 32'h64, 32'h0000_0002, 32'hFFFF_FFFF, 2);
      run_txn(2'b01, 1, 0, 3'b000, 5'd31, 32'h1234_5678, 32'h0000_0900, 32'h0, 0);
      run_txn(2'b11, 0, 1, 3'b000, 5'd3, 32'h68, 32'h0000_0A00, 32'h0, 0);
      reset_mid_wait();

      for (int n = 0; n < 150; n++) begin
         r = $urandom_range(0, 9);
         dly = (r < 5) ? 0 : (r < 9) ? $urandom_range(1, MT - 1) : $urandom_range(MT, MT + 3);
         run_txn(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 3'($urandom_range(0, 7)),
                 ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
                 $urandom, $urandom, $urandom, dly);
      end

      repeat (5) @(posedge clk);
      #1;
      check("queue_drained", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/writeback_pipe.md
WRITEBACK_PIPE -- requirements
Module: writeback_pipe

Interface
REQ-001 Parameter XLEN, default 32, datapath width; legal values 32 and 64.
REQ-002 Parameter MEM_TIMEOUT, default 16, max wait cycles for load data; legal range 2..255.
REQ-003 clk  input  1  single clock, rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 phase_writeback  input  1  writeback phase request from state machine.
REQ-006 use_rd  input  2  result source: 00 ALU, 01 PC, 10 MEMORY, 11 COMP.
REQ-007 jump_en  input  1  op permits jump.
REQ-008 jump_state_mw  input  1  compare/jump result.
REQ-009 ld_funct3  input  3  load size/sign: 000 LB, 001 LH, 010 LW, 011 LD (XLEN=64 only), 100 LBU, 101 LHU, 110 LWU (XLEN=64 only).
REQ-010 rdsel_mw  input  5  destination register.
REQ-011 next_pc_mw, alu_out_mw, mem_out_mw  input  XLEN each  result candidates; alu_out_mw also carries the load address.
REQ-012 mem_ready  input  1  mem_out_mw valid this cycle.
REQ-013 rd_we  output  1  register-file write strobe.
REQ-014 rdsel_wr  output  5; rddata_wr  output  XLEN  write address/data.
REQ-015 jump_state_wf  output  1; regdata_for_pc  output  XLEN  jump request and target to fetch.
REQ-016 stall_writeback  output  1  stall to state machine.
REQ-017 wb_err  output  1  load-timeout pulse.
REQ-018 fwd_valid  output  1; fwd_rdsel  output  5; fwd_data  output  XLEN  bypass of last committed write.

Function
REQ-019 FSM states IDLE, WAIT_MEM, COMMIT; reset state IDLE.
REQ-020 IDLE, phase_writeback=1, (use_rd!=10 or mem_ready=1): capture operands, go COMMIT.
REQ-021 IDLE, phase_writeback=1, use_rd=10, mem_ready=0: capture non-memory operands, clear wait counter, go WAIT_MEM.
REQ-022 WAIT_MEM: counter +1 per cycle; mem_ready=1 -> capture mem_out_mw, go COMMIT; counter reaching MEM_TIMEOUT-1 without mem_ready -> pulse wb_err one cycle, no write, go IDLE.
REQ-023 mem_ready and timeout in same cycle: mem_ready wins, no wb_err.
REQ-024 COMMIT lasts exactly one cycle, then IDLE; rd_we=1 during COMMIT only, except rd_we=0 when rdsel=0.
REQ-025 Latency: phase_writeback with data ready at edge N -> rd_we high in cycle N+1.
REQ-026 rddata_wr by use_rd: 00 alu_out_mw; 01 next_pc_mw; 10 extended load data; 11 zero-extended jump_state_mw.
REQ-027 Load extraction: offset = alu_out_mw[1:0] (XLEN=32) or [2:0] (XLEN=64), byte lanes little-endian; LB/LH/LW sign-extend, LBU/LHU/LWU zero-extend; misaligned halfword/word uses lanes from offset rounded down to natural alignment.
REQ-028 Unlisted ld_funct3 code: rddata_wr = zero, write still performed.
REQ-029 jump_state_wf = jump_en & jump_state_mw, asserted in COMMIT only; regdata_for_pc = captured alu_out_mw, held stable outside COMMIT.
REQ-030 stall_writeback = 1 in WAIT_MEM and combinationally in IDLE under REQ-021 condition; else 0.
REQ-031 phase_writeback in WAIT_MEM or COMMIT ignored.
REQ-032 fwd_*: updated at end of each COMMIT with rd_we=1; held otherwise; fwd_valid stays 1 once set until reset.
REQ-033 rdsel_wr, rddata_wr registered; hold last values outside COMMIT.

Reset
REQ-034 rst_n=0: immediately IDLE, counter 0, all outputs 0, regardless of state.
REQ-035 Reset during WAIT_MEM: pending load discarded, no rd_we, no wb_err after release.

Verification
REQ-036 use_rd=00, rdsel=5, alu_out=0x1234 -> next cycle rd_we=1, rdsel_wr=5, rddata_wr=0x00001234, stall=0.
REQ-037 LB, alu_out[1:0]=3, mem_out=0x80FF_0000, mem_ready=1 -> rddata_wr=0xFFFFFF80; LBU same -> 0x00000080.
REQ-038 LW, mem_ready low 3 cycles then high -> stall 4 cycles, rd_we one cycle after mem_ready.
REQ-039 LW, mem_ready never, MEM_TIMEOUT=16 -> wb_err pulse after 16 stall cycles, rd_we never, IDLE.
REQ-040 use_rd=11, jump_en=1, jump_state=1, rdsel=0 -> jump_state_wf=1, rd_we=0, fwd_valid unchanged.
REQ-041 rst_n low mid-WAIT_MEM -> all outputs 0 immediately; no write or wb_err after release.
